alu_mc: RTL and testbench

Parametrised multi-cycle ALU: the successor to the single-cycle ALU used in the datapath. It keeps the existing single-cycle operation codes (AND, OR, ADD, SUB, SLT, NOR) and adds iterative unsigned multiply and divide. It has a start/busy/done handshake and registered results. It sits in the EX stage of the multi-cycle CPU, and the controller stalls on `busy_o`.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 33 +++
 rtl/alu_mc.sv | 162 ++++++++++++++++
 tb/tb_alu_mc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU family (multi-cycle ALU, its
// combinational evaluator and the CPU ALU-control decoder).
//   ALU_CTRL_W  : width of the ALU operation code
//   ALU_*       : operation-code constants
//   alu_state_t : multi-cycle ALU controller states
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULU = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational evaluator for the single-cycle ALU operations.
//   a_i      in  WIDTH : operand A (signed for SLT)
//   b_i      in  WIDTH : operand B (signed for SLT)
//   ctrl_i   in  4     : operation code
//   result_o out WIDTH : result; 0 for MULU/DIVU and undefined codes
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    input  logic [ALU_CTRL_W-1:0] ctrl_i,
    output logic [WIDTH-1:0]      result_o
);

    logic lt;

    always_comb begin
        lt = $signed(a_i) < $signed(b_i);
        result_o = '0;
        case (ctrl_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = WIDTH'(lt);
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/busy/done handshake. Single-cycle ops
// complete one cycle after accept; MULU (shift-add) and DIVU (restoring)
// take WIDTH+1 cycles. Results are registered and held until the next done.
//   clk_i    in  1     : clock
//   rst_i    in  1     : asynchronous active-high reset
//   start_i  in  1     : request, accepted only while idle
//   src1_i   in  WIDTH : operand A
//   src2_i   in  WIDTH : operand B
//   ctrl_i   in  4     : operation code, sampled at accept
//   busy_o   out 1     : high from the cycle after accept through done
//   done_o   out 1     : one-cycle completion pulse
//   result_o out WIDTH : main result (MULU low half, DIVU quotient)
//   hi_o     out WIDTH : MULU high half / DIVU remainder, else 0
//   zero_o   out 1     : result_o == 0
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      src1_i,
    input  logic [WIDTH-1:0]      src2_i,
    input  logic [ALU_CTRL_W-1:0] ctrl_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      result_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic                  zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_t       state;
    logic [CNT_W-1:0] count;
    // work_hi: product high half (MUL) or WIDTH+1-bit partial remainder (DIV)
    // work_lo: multiplier shifting out / product low half (MUL),
    //          dividend shifting out / quotient shifting in (DIV)
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] opd;      // multiplicand (MUL) or divisor (DIV)

    logic [WIDTH-1:0] comb_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   div_rem_nx;
    logic [WIDTH-1:0] div_q_nx;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a_i      (src1_i),
        .b_i      (src2_i),
        .ctrl_i   (ctrl_i),
        .result_o (comb_res)
    );

    // One shift-add step: the sum's LSB drops into the low half while the
    // multiplier shifts out, so {hi,lo} holds the full product after WIDTH steps.
    always_comb begin
        mul_sum   = work_hi + (work_lo[0] ? {1'b0, opd} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], work_lo[WIDTH-1:1]};
    end

    // One restoring-division step. A zero divisor always "fits", which yields
    // an all-ones quotient and leaves the dividend as remainder with no
    // special case and unchanged latency.
    always_comb begin
        div_shift  = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, opd};
        div_diff   = div_shift - {1'b0, opd};
        div_rem_nx = div_ge ? div_diff : div_shift;
        div_q_nx   = {work_lo[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            opd      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            hi_o     <= '0;
            zero_o   <= 1'b1;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        count  <= CNT_W'(WIDTH);
                        busy_o <= 1'b1;
                        case (ctrl_i)
                            ALU_MULU: begin
                                state   <= ST_MUL;
                                opd     <= src1_i;
                                work_hi <= '0;
                                work_lo <= src2_i;
                            end
                            ALU_DIVU: begin
                                state   <= ST_DIV;
                                opd     <= src2_i;
                                work_hi <= '0;
                                work_lo <= src1_i;
                            end
                            default: begin
                                state    <= ST_DONE;
                                done_o   <= 1'b1;
                                result_o <= comb_res;
                                hi_o     <= '0;
                                zero_o   <= (comb_res == '0);
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    count   <= count - CNT_W'(1);
                    work_hi <= {1'b0, mul_hi_nx};
                    work_lo <= mul_lo_nx;
                    if (count == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        done_o   <= 1'b1;
                        result_o <= mul_lo_nx;
                        hi_o     <= mul_hi_nx;
                        zero_o   <= (mul_lo_nx == '0);
                    end
                end
                ST_DIV: begin
                    count   <= count - CNT_W'(1);
                    work_hi <= div_rem_nx;
                    work_lo <= div_q_nx;
                    if (count == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        done_o   <= 1'b1;
                        result_o <= div_q_nx;
                        hi_o     <= div_rem_nx[WIDTH-1:0];
                        zero_o   <= (div_q_nx == '0);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc (WIDTH=32).
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   ctrl = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .src1_i   (src1),
        .src2_i   (src2),
        .ctrl_i   (ctrl),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .hi_o     (hi),
        .zero_o   (zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int unsigned done_cnt = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        int unsigned  lat;
        int unsigned  acc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every done pulse; between pulses the
    // registered results must hold.
    logic [W-1:0] prev_res = '0;
    logic [W-1:0] prev_hi  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_zero"}, W'(zero), W'(e.res == '0));
                    check({e.name, "_latency"}, W'(cyc - e.acc), W'(e.lat));
                    check({e.name, "_busy_in_done"}, W'(busy), W'(1));
                end
            end else begin
                check("hold_result", result, prev_res);
                check("hold_hi", hi, prev_hi);
            end
        end
        prev_res = result;
        prev_hi  = hi;
    end

    // Issue one request at a negedge; returns at the negedge of the cycle
    // after accept with operands scrambled to prove they were latched.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [W-1:0] eh,
                         input int unsigned el, input bit push, input bit hold);
        int unsigned guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_issue_timeout: got busy_o=1 expected 0", name);
        end
        ctrl  = op;
        src1  = a;
        src2  = b;
        start = 1'b1;
        if (push) sb.push_back('{name, er, eh, el, cyc});
        @(negedge clk);
        if (!hold) start = 1'b0;
        src1 = ~a;
        src2 = b ^ 32'h5A5A_A5A5;
        ctrl = 4'd2;
    endtask

    initial begin
        int unsigned d0;
        int unsigned guard;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",   W'(busy), W'(0));
        check("reset_done",   W'(done), W'(0));
        check("reset_result", result,   32'h0);
        check("reset_hi",     hi,       32'h0);
        check("reset_zero",   W'(zero), W'(1));

        // single-cycle ops, issued back to back
        issue("add_ovf",  4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1, 1'b1, 1'b0);
        issue("sub_eq",   4'd6,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1, 1'b1, 1'b0);
        issue("slt_neg",  4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1, 1'b1, 1'b0);
        issue("slt_pos",  4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1, 1'b1, 1'b0);
        issue("nor_zero", 4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1, 1'b0);
        issue("and",      4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1, 1'b1, 1'b0);
        issue("or",       4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0, 1, 1'b1, 1'b0);
        issue("add_wrap", 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1, 1'b1, 1'b0);
        issue("bad_op",   4'd5,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 32'h0, 1, 1'b1, 1'b0);

        // MULU max x max, busy high in cycles 1..33, low afterwards
        issue("mulu_max", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 1'b1, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            check("mulu_busy", W'(busy), W'(1));
            @(negedge clk);
        end
        check("mulu_busy_after", W'(busy), W'(0));

        issue("divu_100_7", 4'd4, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1, 1'b0);
        issue("divu_by0",   4'd4, 32'd9,   32'd0, 32'hFFFF_FFFF, 32'd9, 33, 1'b1, 1'b0);

        // start held through MULU and its done cycle; operands change after accept
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        d0 = done_cnt;
        issue("mulu_hold", 4'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 33, 1'b1, 1'b1);
        repeat (33) @(negedge clk);
        start = 1'b0;
        check("hold_done_count", W'(done_cnt - d0), W'(1));
        check("hold_idle_after", W'(busy), W'(0));

        // reset in cycle 10 of a DIVU aborts it with no done pulse
        issue("add_pre", 4'd2, 32'd3, 32'd4, 32'd7, 32'h0, 1, 1'b1, 1'b0);
        issue("divu_abort", 4'd4, 32'd1000, 32'd3, 32'h0, 32'h0, 33, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",   W'(busy), W'(0));
        check("abort_done",   W'(done), W'(0));
        check("abort_result", result,   32'h0);
        check("abort_hi",     hi,       32'h0);
        check("abort_zero",   W'(zero), W'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", W'(busy), W'(0));
        issue("add_post", 4'd2, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h0, 1, 1'b1, 1'b0);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
